// File: rtl/up2_fetch_unit.sv
// rtl/up2_fetch_unit.sv - up2 instruction-fetch demonstrator: UART-loaded 16-byte imem, stepped fetch, UART echo
module up2_fetch_unit #(
    parameter int CLK_FREQ = 50000000,
    parameter int BAUD     = 115200,
    parameter int STEP_DIV = 50000000
) (
    input  logic clk,
    input  logic nRst,
    input  logic rx,
    input  logic sw2,
    input  logic sw1,
    input  logic sw0,
    output logic tx,
    output logic led4,
    output logic led3,
    output logic led2,
    output logic led1,
    output logic led0
);

    localparam int CPB = CLK_FREQ / BAUD;
    localparam int CW  = $clog2(CPB + 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CPB - 1);
    // Mid-bit point of the start bit; clamp so a tiny CPB cannot underflow.
    localparam logic [CW-1:0] HALF_LAST = CW'((CPB / 2 > 0) ? (CPB / 2 - 1) : 0);
    localparam int SW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [SW-1:0] STEP_LAST = SW'(STEP_DIV - 1);

    typedef enum logic [1:0] {
        U_IDLE,
        U_START,
        U_DATA,
        U_STOP
    } uart_state_t;

    // ------------------------------------------------------------------
    // Input synchronisers and edge detection
    // ------------------------------------------------------------------
    logic [1:0] rx_sync;
    logic [1:0] sw0_sync;
    logic [1:0] sw1_sync;
    logic [1:0] sw2_sync;
    logic       rx_s;
    logic       sw0_s;
    logic       sw1_s;
    logic       sw2_s;
    logic       rx_prev;
    logic       rx_armed;
    logic       sw0_prev;
    logic       sw0_rise;
    logic       sw0_fall;

    // Two-flop synchronisers for the asynchronous rx line and switches.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            rx_sync  <= 2'b00;
            sw0_sync <= 2'b00;
            sw1_sync <= 2'b00;
            sw2_sync <= 2'b00;
        end else begin
            rx_sync  <= {rx_sync[0], rx};
            sw0_sync <= {sw0_sync[0], sw0};
            sw1_sync <= {sw1_sync[0], sw1};
            sw2_sync <= {sw2_sync[0], sw2};
        end
    end

    assign rx_s  = rx_sync[1];
    assign sw0_s = sw0_sync[1];
    assign sw1_s = sw1_sync[1];
    assign sw2_s = sw2_sync[1];

    // Previous-value history; the receiver arms only once an idle-high line is seen.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            rx_prev  <= 1'b0;
            rx_armed <= 1'b0;
            sw0_prev <= 1'b0;
        end else begin
            rx_prev  <= rx_s;
            rx_armed <= rx_armed | rx_s;
            sw0_prev <= sw0_s;
        end
    end

    assign sw0_rise = sw0_s & ~sw0_prev;
    assign sw0_fall = ~sw0_s & sw0_prev;

    // ------------------------------------------------------------------
    // UART receiver
    // ------------------------------------------------------------------
    uart_state_t   rx_state, rx_state_n;
    logic [CW-1:0] rx_cnt, rx_cnt_n;
    logic [2:0]    rx_bit, rx_bit_n;
    logic [7:0]    rx_shift, rx_shift_n;
    logic          rx_valid, rx_valid_n;

    // Receiver state register.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            rx_state <= U_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= 3'd0;
            rx_shift <= 8'h00;
            rx_valid <= 1'b0;
        end else begin
            rx_state <= rx_state_n;
            rx_cnt   <= rx_cnt_n;
            rx_bit   <= rx_bit_n;
            rx_shift <= rx_shift_n;
            rx_valid <= rx_valid_n;
        end
    end

    // Receiver next state. A framing error needs no extra state: a new start
    // is only taken on a high-to-low edge, so the line must return high first.
    always_comb begin
        rx_state_n = rx_state;
        rx_cnt_n   = rx_cnt;
        rx_bit_n   = rx_bit;
        rx_shift_n = rx_shift;
        rx_valid_n = 1'b0;
        case (rx_state)
            U_IDLE: begin
                if (rx_armed && rx_prev && !rx_s) begin
                    rx_state_n = U_START;
                    rx_cnt_n   = '0;
                end
            end
            U_START: begin
                if (rx_cnt == HALF_LAST) begin
                    rx_cnt_n = '0;
                    rx_bit_n = 3'd0;
                    rx_state_n = rx_s ? U_IDLE : U_DATA;
                end else begin
                    rx_cnt_n = rx_cnt + CW'(1);
                end
            end
            U_DATA: begin
                if (rx_cnt == BIT_LAST) begin
                    rx_cnt_n   = '0;
                    rx_shift_n = {rx_s, rx_shift[7:1]};
                    if (rx_bit == 3'd7) begin
                        rx_state_n = U_STOP;
                    end else begin
                        rx_bit_n = rx_bit + 3'd1;
                    end
                end else begin
                    rx_cnt_n = rx_cnt + CW'(1);
                end
            end
            U_STOP: begin
                if (rx_cnt == BIT_LAST) begin
                    rx_cnt_n   = '0;
                    rx_valid_n = rx_s;
                    rx_state_n = U_IDLE;
                end else begin
                    rx_cnt_n = rx_cnt + CW'(1);
                end
            end
            default: rx_state_n = U_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Instruction memory and load pointer
    // ------------------------------------------------------------------
    logic [7:0] imem [16];
    logic [3:0] wr_ptr;

    // Load-mode writes; leaving run mode rewinds the write pointer.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            wr_ptr <= 4'd0;
            for (int i = 0; i < 16; i++) begin
                imem[i] <= 8'h00;
            end
        end else if (sw0_fall) begin
            wr_ptr <= 4'd0;
        end else if (!sw0_s && rx_valid) begin
            imem[wr_ptr] <= rx_shift;
            wr_ptr       <= wr_ptr + 4'd1;
        end
    end

    // ------------------------------------------------------------------
    // Step timing and fetch
    // ------------------------------------------------------------------
    logic [SW-1:0] step_cnt;
    logic [3:0]    pc;
    logic [7:0]    instr;
    logic          valid;
    logic          pend;
    logic          tx_start;
    logic          step_tick;
    logic          tx_idle;
    logic          fetch_go;
    uart_state_t   tx_state;

    // tx_start counts as busy so a tick in that cycle cannot fetch twice.
    assign tx_idle   = (tx_state == U_IDLE) && !tx_start;
    assign step_tick = sw0_s && !sw1_s && !sw0_rise && (step_cnt == STEP_LAST);
    assign fetch_go  = sw0_s && !sw1_s && !sw0_rise && (step_tick || pend) && tx_idle;

    // Step counter, single-deep pending tick, and the fetch itself.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            step_cnt <= '0;
            pc       <= 4'd0;
            instr    <= 8'h00;
            valid    <= 1'b0;
            pend     <= 1'b0;
            tx_start <= 1'b0;
        end else begin
            tx_start <= fetch_go;
            if (sw0_rise) begin
                step_cnt <= '0;
                pc       <= 4'd0;
                valid    <= 1'b0;
                pend     <= 1'b0;
            end else if (sw0_s) begin
                if (!sw1_s) begin
                    step_cnt <= step_tick ? '0 : step_cnt + SW'(1);
                end
                if (fetch_go) begin
                    instr <= imem[pc];
                    valid <= 1'b1;
                    pc    <= pc + 4'd1;
                    pend  <= 1'b0;
                end else if (step_tick) begin
                    pend <= 1'b1;
                end
            end else begin
                step_cnt <= '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // UART transmitter
    // ------------------------------------------------------------------
    uart_state_t   tx_state_n;
    logic [CW-1:0] tx_cnt, tx_cnt_n;
    logic [2:0]    tx_bit, tx_bit_n;
    logic [7:0]    tx_shift, tx_shift_n;

    // Transmitter state register.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            tx_state <= U_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= 3'd0;
            tx_shift <= 8'h00;
        end else begin
            tx_state <= tx_state_n;
            tx_cnt   <= tx_cnt_n;
            tx_bit   <= tx_bit_n;
            tx_shift <= tx_shift_n;
        end
    end

    // Transmitter next state: start, 8 data bits LSB first, stop, each CPB clocks.
    always_comb begin
        tx_state_n = tx_state;
        tx_cnt_n   = tx_cnt;
        tx_bit_n   = tx_bit;
        tx_shift_n = tx_shift;
        case (tx_state)
            U_IDLE: begin
                if (tx_start) begin
                    tx_state_n = U_START;
                    tx_cnt_n   = '0;
                    tx_shift_n = instr;
                end
            end
            U_START: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_n   = '0;
                    tx_bit_n   = 3'd0;
                    tx_state_n = U_DATA;
                end else begin
                    tx_cnt_n = tx_cnt + CW'(1);
                end
            end
            U_DATA: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_n   = '0;
                    tx_shift_n = {1'b0, tx_shift[7:1]};
                    if (tx_bit == 3'd7) begin
                        tx_state_n = U_STOP;
                    end else begin
                        tx_bit_n = tx_bit + 3'd1;
                    end
                end else begin
                    tx_cnt_n = tx_cnt + CW'(1);
                end
            end
            U_STOP: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_n   = '0;
                    tx_state_n = U_IDLE;
                end else begin
                    tx_cnt_n = tx_cnt + CW'(1);
                end
            end
            default: tx_state_n = U_IDLE;
        endcase
    end

    assign tx = (tx_state == U_START) ? 1'b0 :
                (tx_state == U_DATA)  ? tx_shift[0] : 1'b1;

    // ------------------------------------------------------------------
    // LED display
    // ------------------------------------------------------------------
    assign {led4, led3, led2, led1, led0} = sw2_s ? instr[4:0] : {valid, pc};

endmodule

// File: tb/tb_up2_fetch_unit.sv
// tb/tb_up2_fetch_unit.sv - scoreboard bench for up2_fetch_unit
module tb_up2_fetch_unit;

    localparam int CLK_FREQ = 1600;
    localparam int BAUD     = 100;
    localparam int STEP_DIV = 4;
    localparam int CPB      = CLK_FREQ / BAUD;

    logic clk  = 1'b0;
    logic nRst = 1'b0;
    logic rx   = 1'b0;
    logic sw0  = 1'b0;
    logic sw1  = 1'b0;
    logic sw2  = 1'b0;
    logic tx;
    logic led4, led3, led2, led1, led0;
    logic [4:0] leds;

    assign leds = {led4, led3, led2, led1, led0};

    up2_fetch_unit #(
        .CLK_FREQ(CLK_FREQ),
        .BAUD    (BAUD),
        .STEP_DIV(STEP_DIV)
    ) dut (
        .clk (clk),
        .nRst(nRst),
        .rx  (rx),
        .sw2 (sw2),
        .sw1 (sw1),
        .sw0 (sw0),
        .tx  (tx),
        .led4(led4),
        .led3(led3),
        .led2(led2),
        .led1(led1),
        .led0(led0)
    );

    always #10 clk = ~clk;

    int         n_checks  = 0;
    int         n_pass    = 0;
    int         frames_rx = 0;
    int         wr_model  = 0;
    logic [7:0] model [16];
    logic [7:0] exp_q [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        @(negedge clk);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        if (stop) begin
            model[wr_model] = b;
            wr_model = (wr_model + 1) % 16;
        end
    endtask

    // TX monitor: decode each frame and compare against the scoreboard.
    initial begin
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (nRst && tx === 1'b0) begin
                repeat (CPB / 2) @(negedge clk);
                check("tx_start_bit", tx, 1'b0);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    b[i] = tx;
                end
                repeat (CPB) @(negedge clk);
                check("tx_stop_bit", tx, 1'b1);
                check("tx_frame_expected", exp_q.size() > 0, 1'b1);
                if (exp_q.size() > 0) check("tx_frame_data", b, exp_q.pop_front());
                frames_rx++;
            end
        end
    end

    initial begin
        for (int i = 0; i < 16; i++) model[i] = 8'h00;

        // Reset with rx held low.
        repeat (3) @(negedge clk);
        check("reset_tx", tx, 1'b1);
        check("reset_leds", leds, 5'd0);
        nRst = 1'b1;
        repeat (500) @(negedge clk);
        check("rx_low_wr_ptr", dut.wr_ptr, 4'd0);
        check("rx_low_imem0", dut.imem[0], 8'h00);
        check("rx_low_leds", leds, 5'd0);

        // Fill all 16 entries and wrap with a 17th byte.
        rx = 1'b1;
        repeat (10) @(negedge clk);
        for (int i = 0; i < 17; i++) send_byte(8'(8'hA0 + i), 1'b1);
        check("wrap_wr_ptr", dut.wr_ptr, 4'd1);
        check("wrap_imem0", dut.imem[0], model[0]);
        check("wrap_imem15", dut.imem[15], model[15]);

        // Halted trip through run mode rewinds the write pointer without fetching.
        sw1 = 1'b1;
        repeat (5) @(negedge clk);
        sw0 = 1'b1;
        repeat (10) @(negedge clk);
        check("halted_run_leds", leds, 5'd0);
        sw0 = 1'b0;
        repeat (5) @(negedge clk);
        sw1 = 1'b0;
        check("rewind_wr_ptr", dut.wr_ptr, 4'd0);
        wr_model = 0;

        // Program load, then a framing error, then a good byte.
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b1);
        check("load3_wr_ptr", dut.wr_ptr, 4'd3);
        check("load3_imem1", dut.imem[1], 8'h22);
        send_byte(8'h55, 1'b0);
        check("frame_err_wr_ptr", dut.wr_ptr, 4'd3);
        check("frame_err_imem3", dut.imem[3], model[3]);
        send_byte(8'h44, 1'b1);
        check("after_err_wr_ptr", dut.wr_ptr, 4'd4);
        check("after_err_imem3", dut.imem[3], 8'h44);

        // Run: expect imem echoed in order, wrapping past address 15.
        for (int i = 0; i < 22; i++) exp_q.push_back(model[i % 16]);
        sw0 = 1'b1;
        for (int k = 0; k < 100 && led4 !== 1'b1; k++) @(negedge clk);
        check("first_fetch_leds", leds, {1'b1, 4'd1});
        sw2 = 1'b1;
        repeat (5) @(negedge clk);
        check("instr_leds", leds, model[0][4:0]);
        sw2 = 1'b0;
        repeat (5) @(negedge clk);
        check("pc_leds_again", leds, {1'b1, 4'd1});

        // Halt during the fourth frame.
        for (int k = 0; k < 2000 && frames_rx < 3; k++) @(negedge clk);
        for (int k = 0; k < 200 && tx !== 1'b0; k++) @(negedge clk);
        repeat (20) @(negedge clk);
        sw1 = 1'b1;
        repeat (5) @(negedge clk);
        check("halt_leds", leds, {1'b1, 4'd4});
        repeat (400) @(negedge clk);
        check("halt_frames", frames_rx, 4);
        check("halt_leds_frozen", leds, {1'b1, 4'd4});
        sw1 = 1'b0;

        for (int k = 0; k < 4000 && frames_rx < 22; k++) @(negedge clk);
        check("frames_total", frames_rx, 22);
        sw0 = 1'b0;
        repeat (200) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        check("no_frames_after_run", frames_rx, 22);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/up2_fetch_unit.md
Name: up2_fetch_unit

Overview:
Board-level instruction-fetch demonstrator for the up2 processor. A 16-entry byte instruction memory is loaded over a UART receive line. The fetch stage walks a program counter through that memory, holds each fetched instruction, and echoes it on the UART transmit line. Three switches select load/run, halt and LED display source; five LEDs show the fetch state.

Parameters:
CLK_FREQ, 50000000, clock frequency in Hz (20 ns period)
BAUD, 115200, UART bit rate; CLKS_PER_BIT = CLK_FREQ/BAUD, integer division (434)
STEP_DIV, 50000000, clocks between fetch steps in run mode (must be ≥ 1)

Ports:
clk  input  1  system clock, rising edge
nRst  input  1  asynchronous active-low reset
rx  input  1  UART receive, 8N1, idle high, asynchronous to clk
sw2  input  1  LED display select
sw1  input  1  halt (1 = hold PC)
sw0  input  1  mode: 0 = load, 1 = run
tx  output  1  UART transmit, 8N1, idle high
led4  output  1  display bit 4
led3  output  1  display bit 3
led2  output  1  display bit 2
led1  output  1  display bit 1
led0  output  1  display bit 0

Behaviour:
- All state resets asynchronously on nRst low: tx=1, leds=0, pc=0, wr_ptr=0, instr=0x00, valid=0, imem all 0x00, UART FSMs idle, step counter 0.
- rx, sw0, sw1 and sw2 each pass through a 2-flop synchroniser.
  - rx synchroniser resets to 0.
  - Switch synchronisers reset to 0.
- RX arming:
  - Receiver is armed only after a synchronised rx=1 has been seen since reset.
  - A line held low from reset produces no byte.
- RX FSM states: IDLE, START, DATA, STOP.
  - IDLE→START on an armed falling edge of rx.
  - START: sample at CLKS_PER_BIT/2. If rx=1, treat as a glitch and return to IDLE.
  - DATA: 8 bits LSB first, each sampled every CLKS_PER_BIT.
  - STOP: sample once. If 1, pulse rx_valid for 1 clk with the byte. If 0, framing error: discard the byte and stay in IDLE until rx returns high.
- Load mode (sw0=0):
  - Each rx_valid writes imem[wr_ptr] = byte; wr_ptr increments mod 16 (wraps 15→0).
  - Fetch is disabled; step counter is held at 0.
- Run mode (sw0=1): received bytes are ignored.
- Mode transitions, on synchronised sw0 edges:
  - Rising edge: pc=0, valid=0, step counter=0.
  - Falling edge: wr_ptr=0.
- Step timing: in run mode with sw1=0, the step counter counts 0..STEP_DIV-1 and raises a step tick on wrap.
- Fetch on step tick:
  - If the TX is idle: instr ← imem[pc] (combinational read), valid ← 1, pc ← pc+1 mod 16, and tx_start pulses the following cycle with instr.
  - If the TX is busy: the tick is held pending and is serviced on the first cycle the TX is idle.
  - Only one pending tick is stored; further ticks are dropped.
- Halt: sw1=1 freezes the step counter, pc and any pending tick. An in-flight TX frame completes. Clearing sw1 resumes the count from its held value.
- TX FSM states: IDLE, START, DATA, STOP.
  - Frame is a start bit 0, 8 data bits LSB first, then stop bit 1, each held CLKS_PER_BIT clocks.
  - Busy from tx_start until the end of the stop bit.
- LED mux (combinational from registers, using synchronised sw2):
  - sw2=0: {led4..led0} = {valid, pc[3:0]}.
  - sw2=1: {led4..led0} = instr[4:0].
- Simultaneous events:
  - rx_valid coinciding with a sw0 rising edge: the mode change wins and the byte is not written.
  - Reset mid-frame aborts both UARTs immediately; tx returns to 1.

Test Plan:
- Reset, with rx=0 and all switches 0 → tx=1, all LEDs 0. Hold rx low for 2 ms → no imem write, wr_ptr stays 0.
- Load mode: raise rx idle, send bytes 0x11, 0x22, 0x33 → imem[0..2]=0x11/0x22/0x33, wr_ptr=3. A 17th byte wraps the write to imem[0].
- sw0→1 with STEP_DIV=4 → pc=1, valid=1, instr=0x11 after the first tick. tx emits the frame for 0x11, then 0x22, 0x33, 0x00…, and pc wraps 15→0.
- sw2 toggling in run mode → LEDs alternate between {1, pc} and instr[4:0] (0x11 gives 10001b).
- sw1=1 mid-run → pc and LEDs frozen, the current tx frame finishes, no new frame starts. sw1=0 resumes from the next address.
- Byte sent with stop bit 0 in load mode → no write, wr_ptr unchanged; the next valid byte is written normally.
